// File: rtl/kf_seq_pkg.sv
// Shared definitions for the Router A command sequencer: command opcodes,
// FSM states and the Router A select encodings.
package kf_seq_pkg;

  // Command opcodes carried on CMD_OP
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_EXEC  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } cmd_op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4,
    ST_CLEAR = 3'd5
  } state_e;

  // sel_data codes: source of the word written into the bank
  localparam logic [1:0] SEL_DATA_IN = 2'd0;
  localparam logic [1:0] SEL_RESULT  = 2'd1;
  localparam logic [1:0] SEL_ZERO    = 2'd2;

  // sel_write codes: bank write enable mode
  localparam logic [1:0] SEL_WR_WR  = 2'd0;
  localparam logic [1:0] SEL_WR_RDY = 2'd1;
  localparam logic [1:0] SEL_WR_OFF = 2'd2;
  localparam logic [1:0] SEL_WR_ON  = 2'd3;

  // Width of the WAIT timeout counter
  localparam int unsigned TMO_CNTW = 8;

endpackage

// File: rtl/router_a_seq.sv
// Router A command sequencer: takes LOAD / EXEC / CLEAR / NOP commands from
// the filter control FSM and drives Router A selects, addresses and the ALU
// launch. All outputs decode from registered state and captured fields.
// Optional feature: define KF_SEQ_TIMEOUT_EN to enable the WAIT timeout
// counter and the sticky ERR flag; otherwise WAIT lasts until READY.
module router_a_seq
  import kf_seq_pkg::*;
#(
  parameter int unsigned ADDRW = 5,
  parameter int unsigned TMO   = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [ADDRW-1:0] CMD_SRCA,
  input  logic [ADDRW-1:0] CMD_SRCB,
  input  logic [ADDRW-1:0] CMD_DST,
  input  logic [ADDRW-1:0] CMD_LEN,
  input  logic             READY,
  output logic             ALU_START,
  output logic [ADDRW-1:0] CTL_A,
  output logic [ADDRW-1:0] CTL_B,
  output logic [ADDRW-1:0] DIR_EXT,
  output logic             WRITE_REQ,
  output logic [1:0]       sel_data,
  output logic             sel_dira,
  output logic             sel_dirb,
  output logic [1:0]       sel_write,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;
  logic [ADDRW-1:0] srca_q, srca_d;
  logic [ADDRW-1:0] srcb_q, srcb_d;
  logic [ADDRW-1:0] dst_q, dst_d;
  logic [ADDRW-1:0] ptr_q, ptr_d;
  logic [ADDRW-1:0] rem_q, rem_d;
  logic             accept;

`ifdef KF_SEQ_TIMEOUT_EN
  logic [TMO_CNTW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                err_q, err_d;
`else
  logic                tmo_unused;
  assign tmo_unused = ^TMO_CNTW'(TMO);
`endif

  assign accept = rdy_q && (state_q == ST_IDLE) && CMD_VALID;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured command fields, CLEAR pointer/count, ready and done flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      srca_q <= '0;
      srcb_q <= '0;
      dst_q  <= '0;
      ptr_q  <= '0;
      rem_q  <= '0;
    end else begin
      rdy_q  <= rdy_d;
      done_q <= done_d;
      srca_q <= srca_d;
      srcb_q <= srcb_d;
      dst_q  <= dst_d;
      ptr_q  <= ptr_d;
      rem_q  <= rem_d;
    end
  end

`ifdef KF_SEQ_TIMEOUT_EN
  // WAIT timeout counter and sticky error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`endif

  // Next-state and next-field logic
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    done_d  = 1'b0;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    dst_d   = dst_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
`ifdef KF_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          srca_d = CMD_SRCA;
          srcb_d = CMD_SRCB;
          dst_d  = CMD_DST;
          ptr_d  = CMD_DST;
          rem_d  = CMD_LEN;
`ifdef KF_SEQ_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          case (cmd_op_e'(CMD_OP))
            OP_LOAD:  state_d = ST_LOAD;
            OP_EXEC:  state_d = ST_READ;
            OP_CLEAR: state_d = ST_CLEAR;
            OP_NOP:   done_d  = 1'b1;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_READ: begin
        state_d = ST_WAIT;
`ifdef KF_SEQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (READY) begin
          state_d = ST_WB;
`ifdef KF_SEQ_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_CNTW'(TMO - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_CNTW'(1);
`endif
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_CLEAR: begin
        if (rem_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - ADDRW'(1);
          ptr_d = ptr_q + ADDRW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Router A select / address decode from the current state
  always_comb begin
    ALU_START = 1'b0;
    CTL_A     = '0;
    CTL_B     = '0;
    DIR_EXT   = '0;
    sel_data  = SEL_DATA_IN;
    sel_dira  = 1'b0;
    sel_dirb  = 1'b0;
    sel_write = SEL_WR_OFF;
    case (state_q)
      ST_LOAD: begin
        sel_data  = SEL_DATA_IN;
        sel_dira  = 1'b1;
        DIR_EXT   = dst_q;
        sel_write = SEL_WR_ON;
      end
      ST_READ: begin
        CTL_A     = srca_q;
        CTL_B     = srcb_q;
        ALU_START = 1'b1;
      end
      ST_WAIT: begin
        CTL_A = srca_q;
        CTL_B = srcb_q;
      end
      ST_WB: begin
        sel_data  = SEL_RESULT;
        sel_dira  = 1'b1;
        DIR_EXT   = dst_q;
        sel_write = SEL_WR_ON;
      end
      ST_CLEAR: begin
        sel_data  = SEL_ZERO;
        sel_dira  = 1'b1;
        DIR_EXT   = ptr_q;
        sel_write = SEL_WR_ON;
      end
      default: ;
    endcase
  end

  // Status outputs
  assign CMD_READY = rdy_q && (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign WRITE_REQ = 1'b1;
`ifdef KF_SEQ_TIMEOUT_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: doc/router_a_seq.md
# router_a_seq

Command sequencer for Router A, the register-bank access router of the Kalman filter datapath. It accepts one command at a time from the filter control FSM: load an external word, execute an ALU operation with write-back, or zero-fill an address range. It drives all of Router A's select, address and write-request lines, and starts and monitors the ALU. It sits between the top-level control FSM and Router A; the bank and ALU are unchanged.

## Interface
- ADDRW, 5, bank address width (matches Router A)
- TMO, 255, maximum WAIT cycles before timeout (8-bit counter; legal range 1..255)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  sequencer can accept; command taken on CMD_VALID & CMD_READY
- CMD_OP  in  2  0=LOAD, 1=EXEC, 2=CLEAR, 3=NOP
- CMD_SRCA / CMD_SRCB  in  ADDRW  EXEC operand addresses
- CMD_DST  in  ADDRW  write address (LOAD/EXEC) or CLEAR start address
- CMD_LEN  in  ADDRW  CLEAR word count minus 1
- READY  in  1  ALU result valid; RESULT held stable until next ALU_START
- ALU_START  out  1  one-cycle ALU launch pulse
- CTL_A / CTL_B  out  ADDRW  operand addresses to Router A
- DIR_EXT  out  ADDRW  write address to Router A
- WRITE_REQ  out  1  tied 1 (writes are controlled via sel_write)
- sel_data  out  2  / sel_dira  out  1 / sel_dirb  out  1 / sel_write  out  2  Router A selects
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  sticky timeout flag; cleared when the next command is accepted

## Operation
- States: IDLE, LOAD, READ, WAIT, WB, CLEAR. On accept, CMD fields are captured into registers and are not sampled again.
- Every output is decoded from registered state and registered fields only. There is no input-to-output combinational path.
- IDLE: CMD_READY=1, sel_write=2 (write disabled), other selects 0.
- LOAD (1 cycle): sel_data=0, sel_dira=1, DIR_EXT=dst, sel_write=3. Next state IDLE.
- EXEC flow:
  - READ (1 cycle): sel_dira=0, sel_dirb=0, CTL_A=srca, CTL_B=srcb, sel_write=2, ALU_START=1.
  - WAIT: CTL_A and CTL_B held, sel_write=2. On READY go to WB.
  - WB (1 cycle): sel_data=1, sel_dira=1, DIR_EXT=dst, sel_write=3. Next state IDLE.
- CLEAR: sel_data=2, sel_dira=1, sel_write=3, DIR_EXT=ptr. ptr starts at dst and increments by 1 modulo 2^ADDRW (wraps 31→0). Runs len+1 cycles; len=0 writes one word, len=31 writes the full bank.
- NOP: accepted, no write, DONE next cycle.
- DONE=1 in the first IDLE cycle after every command.

## Timing
- Reset values: CMD_READY=1 after release (0 while RST high), ALU_START=0, BUSY=0, DONE=0, ERR=0, sel_write=2, sel_data=0, sel_dira=0, sel_dirb=0, CTL_A=CTL_B=DIR_EXT=0, WRITE_REQ=1.
- Accept at edge E:
  - LOAD writes in cycle E+1; DONE in E+2. Back-to-back LOAD throughput is 1 per 2 cycles.
  - EXEC: READ in E+1; WAIT starts at E+2.
- READY is ignored during READ. It is sampled from the first WAIT cycle onward.
- READY sampled at cycle k: WB in k+1, DONE in k+2.
- CLEAR of n words: writes in E+1..E+n; DONE in E+n+1.
- Timeout: WAIT counter hits TMO without READY → IDLE, ERR=1, DONE=1, no write-back. If READY and timeout occur in the same cycle, READY wins.
- RST mid-command: asynchronously forces IDLE and sel_write=2 immediately. The command is lost and no DONE is issued.

## Configuration
- KF_SEQ_TIMEOUT_EN defined: WAIT timeout counter and ERR are implemented as above.
- KF_SEQ_TIMEOUT_EN undefined: no counter; WAIT lasts until READY, indefinitely. ERR is tied 0 and TMO is unused.

## Structure
- Shared package kf_seq_pkg holds:
  - CMD_OP encodings
  - state enum
  - sel_data codes (DATA_IN=0, RESULT=1, ZERO=2)
  - sel_write codes (WR=0, WR_RDY=1, OFF=2, ON=3)
- Single module. No sub-module; the output decode stays a case on state.

## Test plan
- Reset: RST pulse mid-CLEAR → sel_write=2 and BUSY=0 within the same cycle; CMD_READY=1 after release.
- LOAD dst=7 → exactly one cycle with sel_write=3, sel_data=0, sel_dira=1, DIR_EXT=7; DONE two cycles after accept.
- EXEC srca=3, srcb=4, dst=9, READY after 5 WAIT cycles → ALU_START single pulse with CTL_A=3, CTL_B=4; WB with sel_data=1, DIR_EXT=9; DONE one cycle after WB.
- CLEAR dst=30, len=3 → DIR_EXT sequence 30, 31, 0, 1 with sel_data=2, sel_write=3; DONE after 4 writes.
- Timeout (macro on, TMO=4): READY never asserted → no write-back, ERR=1, DONE=1. Next accepted command clears ERR.
- Stale READY=1 during READ ignored; READY and timeout in the same cycle → WB taken, ERR=0.
